// File: rtl/xadc_drp_master.sv
// DRP initiator for the XADC: one status read per end-of-conversion, plus
// single configuration writes requested by control logic. Every DRP
// transaction is bounded by a timeout so a missing drdy cannot hang the port.
module xadc_drp_master #(
  parameter logic [6:0] CHANNEL_ADDR    = 7'h1F,
  parameter int         USE_EOC_CHANNEL = 0,
  parameter int         TIMEOUT_CYCLES  = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        eoc_in,
  input  logic [4:0]  channel_in,
  input  logic        cfg_wr_req,
  input  logic [6:0]  cfg_wr_addr,
  input  logic [15:0] cfg_wr_data,
  output logic        cfg_wr_ack,
  output logic        drp_den,
  output logic        drp_dwe,
  output logic [6:0]  drp_daddr,
  output logic [15:0] drp_di,
  input  logic [15:0] drp_do,
  input  logic        drp_drdy,
  output logic        sample_valid,
  output logic [15:0] sample_data,
  output logic [11:0] sample_code,
  output logic [6:0]  sample_addr,
  output logic        overrun,
  output logic        timeout_err,
  output logic        busy
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_REQ,
    S_RD_WAIT,
    S_WR_REQ,
    S_WR_WAIT
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic             r_eoc_q;
  logic             r_rd_pend;
  logic [6:0]       r_rd_addr;
  logic [6:0]       r_daddr;
  logic [15:0]      r_di;
  logic [CNT_W-1:0] r_cnt;
  logic             r_sample_valid;
  logic [15:0]      r_sample_data;
  logic [6:0]       r_sample_addr;
  logic             r_overrun;
  logic             r_timeout_err;
  logic             r_wr_ack;

  logic       w_eoc_rise;
  logic [6:0] w_new_addr;
  logic       w_consume;
  logic       w_start_rd;
  logic       w_start_wr;
  logic       w_cnt_last;
  logic       w_rd_done;
  logic       w_wr_done;
  logic       w_rd_to;
  logic       w_wr_to;

  assign w_eoc_rise = eoc_in & ~r_eoc_q;
  assign w_new_addr = (USE_EOC_CHANNEL != 0) ? {2'b00, channel_in} : CHANNEL_ADDR;
  assign w_consume  = (r_state == S_IDLE) & r_rd_pend;
  assign w_start_rd = w_consume;
  // A conversion arriving this very cycle still beats a waiting write, so a
  // simultaneous eoc/write request always completes the read first.
  assign w_start_wr = (r_state == S_IDLE) & ~r_rd_pend & cfg_wr_req & ~w_eoc_rise;
  assign w_cnt_last = (r_cnt == CNT_LAST);
  assign w_rd_done  = (r_state == S_RD_WAIT) & drp_drdy;
  assign w_wr_done  = (r_state == S_WR_WAIT) & drp_drdy;
  assign w_rd_to    = (r_state == S_RD_WAIT) & ~drp_drdy & w_cnt_last;
  assign w_wr_to    = (r_state == S_WR_WAIT) & ~drp_drdy & w_cnt_last;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state decode; drdy outside the WAIT states has no effect
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start_rd)      w_state_nxt = S_RD_REQ;
        else if (w_start_wr) w_state_nxt = S_WR_REQ;
      end
      S_RD_REQ:  w_state_nxt = S_RD_WAIT;
      S_RD_WAIT: if (w_rd_done || w_rd_to) w_state_nxt = S_IDLE;
      S_WR_REQ:  w_state_nxt = S_WR_WAIT;
      S_WR_WAIT: if (w_wr_done || w_wr_to) w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // eoc edge detection, pending-read flag and overrun detection
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_eoc_q   <= 1'b0;
      r_rd_pend <= 1'b0;
      r_rd_addr <= 7'd0;
      r_overrun <= 1'b0;
    end else begin
      r_eoc_q   <= eoc_in;
      r_overrun <= w_eoc_rise & r_rd_pend & ~w_consume;
      if (w_eoc_rise) begin
        r_rd_pend <= 1'b1;
        r_rd_addr <= w_new_addr;
      end else if (w_consume) begin
        r_rd_pend <= 1'b0;
      end
    end
  end

  // DRP address/data capture at request start; held until the next request
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_daddr <= 7'd0;
      r_di    <= 16'd0;
    end else if (w_start_rd) begin
      r_daddr <= r_rd_addr;
    end else if (w_start_wr) begin
      r_daddr <= cfg_wr_addr;
      r_di    <= cfg_wr_data;
    end
  end

  // Timeout counter: cleared entering a REQ state, counts during WAIT states
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (w_start_rd || w_start_wr) begin
      r_cnt <= '0;
    end else if (r_state == S_RD_WAIT || r_state == S_WR_WAIT) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Completion strobes and the returned sample
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sample_valid <= 1'b0;
      r_sample_data  <= 16'd0;
      r_sample_addr  <= 7'd0;
      r_timeout_err  <= 1'b0;
      r_wr_ack       <= 1'b0;
    end else begin
      r_sample_valid <= w_rd_done;
      r_timeout_err  <= w_rd_to | w_wr_to;
      r_wr_ack       <= w_wr_done | w_wr_to;
      if (w_rd_done) begin
        r_sample_data <= drp_do;
        r_sample_addr <= r_daddr;
      end
    end
  end

  assign drp_den      = (r_state == S_RD_REQ) | (r_state == S_WR_REQ);
  assign drp_dwe      = (r_state == S_WR_REQ);
  assign drp_daddr    = r_daddr;
  assign drp_di       = r_di;
  assign busy         = (r_state != S_IDLE);
  assign sample_valid = r_sample_valid;
  assign sample_data  = r_sample_data;
  assign sample_code  = r_sample_data[15:4];
  assign sample_addr  = r_sample_addr;
  assign overrun      = r_overrun;
  assign timeout_err  = r_timeout_err;
  assign cfg_wr_ack   = r_wr_ack;

endmodule

// File: tb/tb_xadc_drp_master.sv
// Bench for xadc_drp_master: instance A uses the fixed status address with the
// default timeout, instance B reads the eoc channel with an 8-cycle timeout.
module tb_xadc_drp_master;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        eoc_in = 1'b0;
  logic [4:0]  channel_in = 5'd0;
  logic        cfg_wr_req = 1'b0;
  logic [6:0]  cfg_wr_addr = 7'h41;
  logic [15:0] cfg_wr_data = 16'h2000;
  logic [15:0] drp_do = 16'd0;
  logic        drp_drdy = 1'b0;

  logic        a_ack, a_den, a_dwe, a_sv, a_ovr, a_to, a_busy;
  logic [6:0]  a_daddr, a_saddr;
  logic [15:0] a_di, a_sdata;
  logic [11:0] a_scode;
  logic        b_ack, b_den, b_dwe, b_sv, b_ovr, b_to, b_busy;
  logic [6:0]  b_daddr, b_saddr;
  logic [15:0] b_di, b_sdata;
  logic [11:0] b_scode;

  int n_checks = 0;
  int n_fail   = 0;
  int den_cnt_b = 0;
  int ovr_cnt_b = 0;
  int sv_cnt_b  = 0;

  always #5 clk = ~clk;

  xadc_drp_master u_a (
    .clk(clk), .reset_n(reset_n), .eoc_in(eoc_in), .channel_in(channel_in),
    .cfg_wr_req(cfg_wr_req), .cfg_wr_addr(cfg_wr_addr), .cfg_wr_data(cfg_wr_data),
    .cfg_wr_ack(a_ack), .drp_den(a_den), .drp_dwe(a_dwe), .drp_daddr(a_daddr),
    .drp_di(a_di), .drp_do(drp_do), .drp_drdy(drp_drdy), .sample_valid(a_sv),
    .sample_data(a_sdata), .sample_code(a_scode), .sample_addr(a_saddr),
    .overrun(a_ovr), .timeout_err(a_to), .busy(a_busy)
  );

  xadc_drp_master #(.CHANNEL_ADDR(7'h1F), .USE_EOC_CHANNEL(1), .TIMEOUT_CYCLES(8)) u_b (
    .clk(clk), .reset_n(reset_n), .eoc_in(eoc_in), .channel_in(channel_in),
    .cfg_wr_req(cfg_wr_req), .cfg_wr_addr(cfg_wr_addr), .cfg_wr_data(cfg_wr_data),
    .cfg_wr_ack(b_ack), .drp_den(b_den), .drp_dwe(b_dwe), .drp_daddr(b_daddr),
    .drp_di(b_di), .drp_do(drp_do), .drp_drdy(drp_drdy), .sample_valid(b_sv),
    .sample_data(b_sdata), .sample_code(b_scode), .sample_addr(b_saddr),
    .overrun(b_ovr), .timeout_err(b_to), .busy(b_busy)
  );

  // Pulse counters for instance B, one count per high cycle
  always @(posedge clk) begin
    if (b_den) den_cnt_b <= den_cnt_b + 1;
    if (b_ovr) ovr_cnt_b <= ovr_cnt_b + 1;
    if (b_sv)  sv_cnt_b  <= sv_cnt_b + 1;
  end

  typedef struct {
    logic        eoc;
    logic        drdy;
    logic [15:0] dout;
    logic        req;
    logic        den;
    logic        dwe;
    logic [6:0]  daddr;
    logic [15:0] di;
    logic        sv;
    logic [15:0] sdata;
    logic        ack;
    logic        busy;
  } vec_t;

  vec_t tbl[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int base_den, base_ovr, base_sv;

  initial begin
    // eoc, drdy, do, req | den, dwe, daddr, di, sv, sdata, ack, busy
    tbl[0]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 7'h00, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 7'h1F, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1};
    tbl[2]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 7'h1F, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1};
    tbl[3]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 7'h1F, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1};
    tbl[4]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 7'h1F, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1};
    tbl[5]  = '{1'b0, 1'b1, 16'hABC0, 1'b0, 1'b0, 1'b0, 7'h1F, 16'h0000, 1'b1, 16'hABC0, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 7'h1F, 16'h0000, 1'b0, 16'hABC0, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 7'h1F, 16'h0000, 1'b0, 16'hABC0, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 7'h1F, 16'h0000, 1'b0, 16'hABC0, 1'b0, 1'b1};
    tbl[9]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 7'h1F, 16'h0000, 1'b0, 16'hABC0, 1'b0, 1'b1};
    tbl[10] = '{1'b0, 1'b1, 16'h1234, 1'b1, 1'b0, 1'b0, 7'h1F, 16'h0000, 1'b1, 16'h1234, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 7'h41, 16'h2000, 1'b0, 16'h1234, 1'b0, 1'b1};
    tbl[12] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 7'h41, 16'h2000, 1'b0, 16'h1234, 1'b0, 1'b1};
    tbl[13] = '{1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 7'h41, 16'h2000, 1'b0, 16'h1234, 1'b1, 1'b0};
    tbl[14] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 7'h41, 16'h2000, 1'b0, 16'h1234, 1'b0, 1'b0};

    // Reset state
    tick();
    tick();
    check("rst a_busy", {31'd0, a_busy}, 32'd0);
    check("rst a_den", {31'd0, a_den}, 32'd0);
    check("rst a_sv", {31'd0, a_sv}, 32'd0);
    check("rst a_sdata", {16'd0, a_sdata}, 32'd0);
    check("rst b_busy", {31'd0, b_busy}, 32'd0);
    reset_n = 1'b1;
    tick();

    // Basic read, then read-before-write priority on instance A
    for (int i = 0; i < 15; i++) begin
      eoc_in     = tbl[i].eoc;
      drp_drdy   = tbl[i].drdy;
      drp_do     = tbl[i].dout;
      cfg_wr_req = tbl[i].req;
      tick();
      check($sformatf("vec%0d den", i),   {31'd0, a_den},   {31'd0, tbl[i].den});
      check($sformatf("vec%0d dwe", i),   {31'd0, a_dwe},   {31'd0, tbl[i].dwe});
      check($sformatf("vec%0d daddr", i), {25'd0, a_daddr}, {25'd0, tbl[i].daddr});
      check($sformatf("vec%0d di", i),    {16'd0, a_di},    {16'd0, tbl[i].di});
      check($sformatf("vec%0d sv", i),    {31'd0, a_sv},    {31'd0, tbl[i].sv});
      check($sformatf("vec%0d sdata", i), {16'd0, a_sdata}, {16'd0, tbl[i].sdata});
      check($sformatf("vec%0d scode", i), {20'd0, a_scode}, {20'd0, tbl[i].sdata[15:4]});
      check($sformatf("vec%0d ack", i),   {31'd0, a_ack},   {31'd0, tbl[i].ack});
      check($sformatf("vec%0d busy", i),  {31'd0, a_busy},  {31'd0, tbl[i].busy});
      check($sformatf("vec%0d ovr", i),   {31'd0, a_ovr},   32'd0);
      check($sformatf("vec%0d to", i),    {31'd0, a_to},    32'd0);
      if (tbl[i].sv) check($sformatf("vec%0d saddr", i), {25'd0, a_saddr}, 32'h1F);
    end
    eoc_in = 1'b0; drp_drdy = 1'b0; cfg_wr_req = 1'b0;

    // Fresh start for instance B
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();

    // Timeout with no drdy, instance B (8-cycle limit)
    base_sv = sv_cnt_b;
    channel_in = 5'h05;
    eoc_in = 1'b1;
    tick();
    eoc_in = 1'b0;
    tick();
    check("to den", {31'd0, b_den}, 32'd1);
    check("to daddr", {25'd0, b_daddr}, 32'h05);
    for (int s = 2; s <= 10; s++) begin
      tick();
      if (s == 9) begin
        check("to busy_before", {31'd0, b_busy}, 32'd1);
        check("to err_before", {31'd0, b_to}, 32'd0);
      end
      if (s == 10) begin
        check("to err", {31'd0, b_to}, 32'd1);
        check("to busy_after", {31'd0, b_busy}, 32'd0);
      end
    end
    // Late drdy in IDLE is ignored
    drp_drdy = 1'b1;
    drp_do = 16'hFFF0;
    tick();
    check("late sv", {31'd0, b_sv}, 32'd0);
    check("late busy", {31'd0, b_busy}, 32'd0);
    check("late err_pulse", {31'd0, b_to}, 32'd0);
    drp_drdy = 1'b0;
    tick();
    check("late sv_count", sv_cnt_b - base_sv, 32'd0);

    // Channel-mode read after the timeout
    channel_in = 5'h13;
    eoc_in = 1'b1;
    tick();
    eoc_in = 1'b0;
    tick();
    check("ch den", {31'd0, b_den}, 32'd1);
    check("ch dwe", {31'd0, b_dwe}, 32'd0);
    check("ch daddr", {25'd0, b_daddr}, 32'h13);
    tick();
    drp_drdy = 1'b1;
    drp_do = 16'h5670;
    tick();
    check("ch sv", {31'd0, b_sv}, 32'd1);
    check("ch saddr", {25'd0, b_saddr}, 32'h13);
    check("ch sdata", {16'd0, b_sdata}, 32'h5670);
    check("ch scode", {20'd0, b_scode}, 32'h567);
    drp_drdy = 1'b0;
    tick();
    check("ch sv_end", {31'd0, b_sv}, 32'd0);

    // Overrun: three eocs while the first read is outstanding
    base_den = den_cnt_b;
    base_ovr = ovr_cnt_b;
    channel_in = 5'h01; eoc_in = 1'b1; tick();
    eoc_in = 1'b0; tick();
    check("ovr den1", {31'd0, b_den}, 32'd1);
    check("ovr daddr1", {25'd0, b_daddr}, 32'h01);
    channel_in = 5'h02; eoc_in = 1'b1; tick();
    check("ovr none_on_2nd", {31'd0, b_ovr}, 32'd0);
    eoc_in = 1'b0; tick();
    channel_in = 5'h03; eoc_in = 1'b1; tick();
    check("ovr pulse", {31'd0, b_ovr}, 32'd1);
    eoc_in = 1'b0; tick();
    check("ovr pulse_end", {31'd0, b_ovr}, 32'd0);
    drp_drdy = 1'b1; drp_do = 16'h1110; tick();
    check("ovr sv1", {31'd0, b_sv}, 32'd1);
    check("ovr saddr1", {25'd0, b_saddr}, 32'h01);
    drp_drdy = 1'b0; tick();
    check("ovr den2", {31'd0, b_den}, 32'd1);
    check("ovr daddr2", {25'd0, b_daddr}, 32'h03);
    tick();
    drp_drdy = 1'b1; drp_do = 16'h2220; tick();
    check("ovr sv2", {31'd0, b_sv}, 32'd1);
    check("ovr saddr2", {25'd0, b_saddr}, 32'h03);
    check("ovr sdata2", {16'd0, b_sdata}, 32'h2220);
    drp_drdy = 1'b0; tick();
    tick();
    check("ovr read_count", den_cnt_b - base_den, 32'd2);
    check("ovr pulse_count", ovr_cnt_b - base_ovr, 32'd1);

    // Asynchronous reset while waiting for drdy
    channel_in = 5'h04; eoc_in = 1'b1; tick();
    eoc_in = 1'b0; tick();
    tick();
    tick();
    check("ar busy_before", {31'd0, b_busy}, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("ar busy", {31'd0, b_busy}, 32'd0);
    check("ar den", {31'd0, b_den}, 32'd0);
    check("ar daddr", {25'd0, b_daddr}, 32'd0);
    check("ar di", {16'd0, b_di}, 32'd0);
    check("ar sdata", {16'd0, b_sdata}, 32'd0);
    check("ar saddr", {25'd0, b_saddr}, 32'd0);
    check("ar ack", {31'd0, b_ack}, 32'd0);
    check("ar sv", {31'd0, b_sv}, 32'd0);
    tick();
    reset_n = 1'b1;
    drp_drdy = 1'b1;
    drp_do = 16'h7770;
    tick();
    check("ar stray_sv", {31'd0, b_sv}, 32'd0);
    check("ar busy_after", {31'd0, b_busy}, 32'd0);
    drp_drdy = 1'b0;
    tick();
    check("ar stray_sdata", {16'd0, b_sdata}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
